// File: rtl/time_set_pkg.sv
// -----------------------------------------------------------------------------
// time_set_pkg
// Shared definitions for the time-setting controller: the controller state
// enum, the hour/minute limits and the field widths used by the counters.
// -----------------------------------------------------------------------------
package time_set_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT_H = 2'd1,
      ST_EDIT_M = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   localparam int unsigned MAX_HOUR = 23;
   localparam int unsigned MAX_MIN  = 59;
   localparam int unsigned HOUR_W   = 5;
   localparam int unsigned MIN_W    = 6;

endpackage : time_set_pkg

// File: rtl/wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Modulo (MAX+1) up/down counter with a parallel load. A loaded value that is
// larger than MAX is clamped to 0. Load wins over inc/dec; inc and dec
// together leave the value unchanged.
//
// Ports
//   clk_d     in   clock, rising edge
//   rst       in   asynchronous active-high reset, value -> 0
//   inc       in   count up, MAX wraps to 0
//   dec       in   count down, 0 wraps to MAX
//   load      in   replace value with load_val (clamped)
//   load_val  in   WIDTH  value to load
//   value     out  WIDTH  current count
// -----------------------------------------------------------------------------
module wrap_counter #(
   parameter int unsigned MAX   = 59,
   parameter int unsigned WIDTH = 6
) (
   input  logic             clk_d,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] value
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   // NOTE: clocked state is written with non-blocking assignments so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk_d or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= (load_val > MAX_V) ? '0 : load_val;
      end else if (inc && !dec) begin
         value <= (value == MAX_V) ? '0 : value + 1'b1;
      end else if (dec && !inc) begin
         value <= (value == '0) ? MAX_V : value - 1'b1;
      end
   end

endmodule : wrap_counter

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
// Button-driven time-setting controller. sel enters edit mode (capturing the
// running time), up/dn adjust the active field, sel switches field, ok
// commits with a one-cycle load strobe. An edit abandoned for TIMEOUT
// flag-free cycles returns to idle without loading. The active field blinks
// with a half-period of BLINK_HALF cycles.
//
// Ports
//   clk_d       in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   up_flag     in   increment pulse
//   dn_flag     in   decrement pulse
//   sel_flag    in   enter edit / switch field pulse
//   ok_flag     in   commit pulse
//   cur_hour    in   5  running hour 0..23
//   cur_min     in   6  running minute 0..59
//   set_hour    out  5  edited hour
//   set_min     out  6  edited minute
//   load        out  one-cycle commit strobe (decoded from state only)
//   editing     out  high in either edit state
//   blink_mask  out  2  bit1 blanks hours, bit0 blanks minutes
// -----------------------------------------------------------------------------
module time_set_ctrl
   import time_set_pkg::*;
#(
   parameter int unsigned BLINK_HALF = 250,
   parameter int unsigned TIMEOUT    = 5000
) (
   input  logic              clk_d,
   input  logic              rst,
   input  logic              up_flag,
   input  logic              dn_flag,
   input  logic              sel_flag,
   input  logic              ok_flag,
   input  logic [HOUR_W-1:0] cur_hour,
   input  logic [MIN_W-1:0]  cur_min,
   output logic [HOUR_W-1:0] set_hour,
   output logic [MIN_W-1:0]  set_min,
   output logic              load,
   output logic              editing,
   output logic [1:0]        blink_mask
);

   localparam int unsigned CNT_W        = 16;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST   = CNT_W'(BLINK_HALF - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] idle_cnt;
   logic [CNT_W-1:0] blink_cnt;
   logic             blink_phase;

   logic any_flag;
   logic in_edit;
   logic timeout_hit;
   logic capture;
   logic field_entry;
   logic adj_en;

   assign any_flag    = up_flag | dn_flag | sel_flag | ok_flag;
   assign in_edit     = (state_q == ST_EDIT_H) || (state_q == ST_EDIT_M);
   assign timeout_hit = !any_flag && (idle_cnt == TIMEOUT_LAST);

   // up/dn only act when neither ok nor sel claims the cycle.
   assign adj_en = in_edit && !ok_flag && !sel_flag;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_d or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave a latch behind.
   always_comb begin
      state_d     = state_q;
      capture     = 1'b0;
      field_entry = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (sel_flag) begin
               state_d     = ST_EDIT_H;
               capture     = 1'b1;
               field_entry = 1'b1;
            end
         end
         ST_EDIT_H: begin
            if (ok_flag) begin
               state_d = ST_COMMIT;
            end else if (sel_flag) begin
               state_d     = ST_EDIT_M;
               field_entry = 1'b1;
            end else if (timeout_hit) begin
               state_d = ST_IDLE;
            end
         end
         ST_EDIT_M: begin
            if (ok_flag) begin
               state_d = ST_COMMIT;
            end else if (sel_flag) begin
               state_d     = ST_EDIT_H;
               field_entry = 1'b1;
            end else if (timeout_hit) begin
               state_d = ST_IDLE;
            end
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Inactivity counter: cleared outside edit and by any flag inside it.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_d or posedge rst) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if (!in_edit || any_flag) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Blink generator: restarts visible on every field entry.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_d or posedge rst) begin
      if (rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (field_entry || !in_edit) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Field counters
   // ---------------------------------------------------------------------------
   wrap_counter #(.MAX(MAX_HOUR), .WIDTH(HOUR_W)) u_hour (
      .clk_d    (clk_d),
      .rst      (rst),
      .inc      (adj_en && (state_q == ST_EDIT_H) && up_flag),
      .dec      (adj_en && (state_q == ST_EDIT_H) && dn_flag),
      .load     (capture),
      .load_val (cur_hour),
      .value    (set_hour)
   );

   wrap_counter #(.MAX(MAX_MIN), .WIDTH(MIN_W)) u_min (
      .clk_d    (clk_d),
      .rst      (rst),
      .inc      (adj_en && (state_q == ST_EDIT_M) && up_flag),
      .dec      (adj_en && (state_q == ST_EDIT_M) && dn_flag),
      .load     (capture),
      .load_val (cur_min),
      .value    (set_min)
   );

   // ---------------------------------------------------------------------------
   // Outputs: decoded from registered state only, never from the flags.
   // ---------------------------------------------------------------------------
   assign load       = (state_q == ST_COMMIT);
   assign editing    = in_edit;
   assign blink_mask = {(state_q == ST_EDIT_H) && blink_phase,
                        (state_q == ST_EDIT_M) && blink_phase};

endmodule : time_set_ctrl

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
// Self-checking bench for time_set_ctrl with BLINK_HALF=4, TIMEOUT=20.
// The reference model tracks mode, field values, cycles since the last flag
// and cycles since field entry, and derives the outputs arithmetically.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

   localparam int BH = 4;
   localparam int TO = 20;

   logic       clk_d = 1'b0;
   logic       rst   = 1'b1;
   logic       up_flag = 1'b0, dn_flag = 1'b0, sel_flag = 1'b0, ok_flag = 1'b0;
   logic [4:0] cur_hour = '0;
   logic [5:0] cur_min  = '0;
   logic [4:0] set_hour;
   logic [5:0] set_min;
   logic       load, editing;
   logic [1:0] blink_mask;

   int checks = 0;
   int errors = 0;
   int loads_seen = 0;

   // Model: mode 0 idle, 1 hour edit, 2 minute edit, 3 commit.
   int m_mode, m_hour, m_min, m_quiet, m_age;

   time_set_ctrl #(.BLINK_HALF(BH), .TIMEOUT(TO)) dut (
      .clk_d      (clk_d),
      .rst        (rst),
      .up_flag    (up_flag),
      .dn_flag    (dn_flag),
      .sel_flag   (sel_flag),
      .ok_flag    (ok_flag),
      .cur_hour   (cur_hour),
      .cur_min    (cur_min),
      .set_hour   (set_hour),
      .set_min    (set_min),
      .load       (load),
      .editing    (editing),
      .blink_mask (blink_mask)
   );

   always #5 clk_d = ~clk_d;

   function automatic logic [14:0] dut_vec();
      return {set_hour, set_min, load, editing, blink_mask};
   endfunction

   function automatic logic [14:0] model_vec();
      logic [1:0] mask;
      mask = 2'b00;
      if (((m_age / BH) % 2) == 1) begin
         if (m_mode == 1) mask = 2'b10;
         else if (m_mode == 2) mask = 2'b01;
      end
      return {5'(m_hour), 6'(m_min), 1'(m_mode == 3),
              1'(m_mode == 1 || m_mode == 2), mask};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_hour = 0; m_min = 0; m_quiet = 0; m_age = 0;
   endtask

   task automatic model_adjust(input int delta);
      if (m_mode == 1) m_hour = (m_hour + 24 + delta) % 24;
      else             m_min  = (m_min + 60 + delta) % 60;
   endtask

   task automatic model_step(input bit u, input bit d, input bit s, input bit o);
      case (m_mode)
         0: if (s) begin
               m_hour  = (int'(cur_hour) <= 23) ? int'(cur_hour) : 0;
               m_min   = (int'(cur_min) <= 59) ? int'(cur_min) : 0;
               m_mode  = 1;
               m_age   = 0;
               m_quiet = 0;
            end
         1, 2: begin
            m_quiet = (u || d || s || o) ? 0 : m_quiet + 1;
            if (o) m_mode = 3;
            else if (s) begin
               m_mode = 3 - m_mode;
               m_age  = 0;
            end else begin
               if (u && !d) model_adjust(1);
               if (d && !u) model_adjust(-1);
               m_age++;
               if (m_quiet >= TO) m_mode = 0;
            end
         end
         default: m_mode = 0;
      endcase
   endtask

   // One clock cycle with the given flags; outputs settle 1 time unit after.
   task automatic tick(input bit u, input bit d, input bit s, input bit o);
      up_flag = u; dn_flag = d; sel_flag = s; ok_flag = o;
      @(posedge clk_d);
      model_step(u, d, s, o);
      #1;
      up_flag = 0; dn_flag = 0; sel_flag = 0; ok_flag = 0;
      if (load) loads_seen++;
   endtask

   task automatic test_reset();
      model_reset();
      #3;
      checks++;
      if (dut_vec() !== 15'd0) begin
         errors++;
         $display("FAIL reset_async: got %h required %h", dut_vec(), 15'd0);
      end
      repeat (2) @(posedge clk_d);
      #2 rst = 1'b0;
      #1;
      tick(1, 0, 0, 1);  // ignored in idle
      checks++;
      if (dut_vec() !== model_vec() || dut_vec() !== 15'd0) begin
         errors++;
         $display("FAIL idle_ignores_flags: got %h required %h", dut_vec(), model_vec());
      end
   endtask

   task automatic test_inc_commit();
      loads_seen = 0;
      cur_hour = 5'd12; cur_min = 6'd34;
      tick(0, 0, 1, 0);
      checks++;
      if ({set_hour, set_min, editing} !== {5'd12, 6'd34, 1'b1}) begin
         errors++;
         $display("FAIL capture: got %0d:%0d ed=%b required 12:34 ed=1", set_hour, set_min, editing);
      end
      repeat (3) tick(1, 0, 0, 0);
      tick(0, 0, 0, 1);
      checks++;
      if ({set_hour, set_min, load, editing} !== {5'd15, 6'd34, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL inc_commit: got %0d:%0d load=%b required 15:34 load=1", set_hour, set_min, load);
      end
      tick(0, 0, 0, 0);
      checks++;
      if (dut_vec() !== model_vec() || load !== 1'b0 || loads_seen != 1) begin
         errors++;
         $display("FAIL inc_commit_idle: got %h loads=%0d required %h loads=1", dut_vec(), loads_seen, model_vec());
      end
   endtask

   task automatic test_wrap_up();
      loads_seen = 0;
      cur_hour = 5'd23; cur_min = 6'd59;
      tick(0, 0, 1, 0);
      tick(1, 0, 0, 0);
      tick(0, 0, 1, 0);
      tick(1, 0, 0, 0);
      checks++;
      if ({set_hour, set_min} !== {5'd0, 6'd0}) begin
         errors++;
         $display("FAIL wrap_up: got %0d:%0d required 0:0", set_hour, set_min);
      end
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 0);
      checks++;
      if (loads_seen != 1 || dut_vec() !== model_vec()) begin
         errors++;
         $display("FAIL wrap_up_load: got loads=%0d vec=%h required loads=1 vec=%h", loads_seen, dut_vec(), model_vec());
      end
   endtask

   task automatic test_wrap_down_timeout();
      loads_seen = 0;
      cur_hour = 5'd0; cur_min = 6'd0;
      tick(0, 0, 1, 0);
      tick(0, 1, 0, 0);
      tick(0, 0, 1, 0);
      tick(0, 1, 0, 0);
      checks++;
      if ({set_hour, set_min, editing} !== {5'd23, 6'd59, 1'b1}) begin
         errors++;
         $display("FAIL wrap_down: got %0d:%0d ed=%b required 23:59 ed=1", set_hour, set_min, editing);
      end
      repeat (TO - 1) tick(0, 0, 0, 0);
      checks++;
      if (editing !== 1'b1 || dut_vec() !== model_vec()) begin
         errors++;
         $display("FAIL timeout_early: got ed=%b vec=%h required ed=1 vec=%h", editing, dut_vec(), model_vec());
      end
      tick(0, 0, 0, 0);
      checks++;
      if ({editing, set_hour, set_min} !== {1'b0, 5'd23, 6'd59} || loads_seen != 0) begin
         errors++;
         $display("FAIL timeout: got ed=%b %0d:%0d loads=%0d required ed=0 23:59 loads=0", editing, set_hour, set_min, loads_seen);
      end
   endtask

   task automatic test_simultaneous();
      cur_hour = 5'd7; cur_min = 6'd30;
      tick(0, 0, 1, 0);
      tick(0, 0, 1, 0);  // now minute field
      tick(1, 1, 0, 0);
      checks++;
      if ({set_hour, set_min, editing} !== {5'd7, 6'd30, 1'b1}) begin
         errors++;
         $display("FAIL up_dn_same: got %0d:%0d ed=%b required 7:30 ed=1", set_hour, set_min, editing);
      end
      tick(1, 0, 1, 1);
      checks++;
      if ({set_hour, set_min, load} !== {5'd7, 6'd30, 1'b1}) begin
         errors++;
         $display("FAIL ok_sel_same: got %0d:%0d load=%b required 7:30 load=1", set_hour, set_min, load);
      end
      tick(0, 0, 0, 0);
   endtask

   task automatic test_blink();
      logic [1:0] exp;
      cur_hour = 5'd1; cur_min = 6'd2;
      tick(0, 0, 1, 0);
      for (int i = 0; i < 12; i++) begin
         exp = (((i / BH) % 2) == 1) ? 2'b10 : 2'b00;
         checks++;
         if (blink_mask !== exp || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL blink_hour[%0d]: got %b required %b", i, blink_mask, exp);
         end
         tick(0, 0, 0, 0);
      end
      tick(0, 0, 1, 0);
      for (int i = 0; i < 12; i++) begin
         exp = (((i / BH) % 2) == 1) ? 2'b01 : 2'b00;
         checks++;
         if (blink_mask !== exp || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL blink_min[%0d]: got %b required %b", i, blink_mask, exp);
         end
         tick(0, 0, 0, 0);
      end
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 0);
   endtask

   task automatic test_reset_commit();
      loads_seen = 0;
      cur_hour = 5'd9; cur_min = 6'd9;
      tick(0, 0, 1, 0);
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 1);
      checks++;
      if (load !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_commit: got load=%b required 1", load);
      end
      #2 rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (dut_vec() !== 15'd0) begin
         errors++;
         $display("FAIL reset_in_commit: got %h required %h", dut_vec(), 15'd0);
      end
      @(posedge clk_d);
      #2 rst = 1'b0;
      loads_seen = 0;
      repeat (5) tick(0, 0, 0, 0);
      checks++;
      if (loads_seen != 0 || dut_vec() !== 15'd0) begin
         errors++;
         $display("FAIL post_reset: got loads=%0d vec=%h required loads=0 vec=0", loads_seen, dut_vec());
      end
   endtask

   task automatic test_random();
      bit u, d, s, o;
      for (int i = 0; i < 600; i++) begin
         cur_hour = 5'($urandom_range(0, 31));
         cur_min  = 6'($urandom_range(0, 63));
         if ((i % 80) >= 55) begin
            u = 0; d = 0; s = 0; o = 0;
         end else begin
            u = ($urandom_range(0, 5) == 0);
            d = ($urandom_range(0, 5) == 0);
            s = ($urandom_range(0, 7) == 0);
            o = ($urandom_range(0, 15) == 0);
         end
         tick(u, d, s, o);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL random[%0d]: got %h required %h", i, dut_vec(), model_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_inc_commit();
      test_wrap_up();
      test_wrap_down_timeout();
      test_simultaneous();
      test_blink();
      test_reset_commit();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_time_set_ctrl
